// File: rtl/msk_aes_mixcol_pipe_if.sv
// msk_aes_mixcol_pipe_if: column stream handshake bundle for the masked MixColumns pipe
interface msk_aes_mixcol_pipe_if #(parameter int d = 2);
    logic            in_valid;
    logic            in_ready;
    logic [32*d-1:0] in_col;
    logic [1:0]      in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [32*d-1:0] out_col;
    logic            out_last;
    logic            busy;
    modport master (output in_valid, in_col, in_mode, out_ready,
                    input  in_ready, out_valid, out_col, out_last, busy);
    modport slave  (input  in_valid, in_col, in_mode, out_ready,
                    output in_ready, out_valid, out_col, out_last, busy);
endinterface

// File: rtl/msk_aes_mixcol_pipe.sv
// msk_aes_mixcol_pipe: share-wise masked AES (Inv)MixColumns, two-stage elastic pipeline
module msk_aes_mixcol_pipe #(
    parameter int d    = 2,
    parameter int NCOL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    msk_aes_mixcol_pipe_if.slave  bus
);
    localparam int CW = NCOL > 1 ? $clog2(NCOL) : 1;
    logic            s1_v, s2_v, s1_last, s2_last, s1_ld, s2_ld, cnt_last;
    logic [1:0]      s1_mode;
    logic [32*d-1:0] s1_col, s2_col, pre, mc;
    logic [CW-1:0]   cnt;
    logic [7:0]      ai [4];
    logic [7:0]      as [4];
    logic [7:0]      ci [4];
    logic [7:0]      bo [4];
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
    assign s2_ld         = !s2_v || bus.out_ready;
    assign s1_ld         = !s1_v || s2_ld;
    assign cnt_last      = cnt == CW'(NCOL - 1);
    assign bus.in_ready  = s1_ld;
    assign bus.out_valid = s2_v;
    assign bus.out_col   = s2_col;
    assign bus.out_last  = s2_last;
    assign bus.busy      = s1_v | s2_v;
    // Each share is unpacked, transformed and repacked on its own: no share mixing.
    always_comb begin
        pre = '0;
        mc  = '0;
        ai  = '{default: '0};
        as  = '{default: '0};
        ci  = '{default: '0};
        bo  = '{default: '0};
        for (int s = 0; s < d; s++) begin
            for (int k = 0; k < 4; k++)
                for (int b = 0; b < 8; b++) begin
                    ai[k][b] = bus.in_col[8*d*k + d*b + s];
                    as[k][b] = s1_col[8*d*k + d*b + s];
                end
            for (int k = 0; k < 4; k++) begin
                ci[k] = bus.in_mode == 2'b01 ? xt(xt(ai[k])) ^ ai[k] ^ xt(xt(ai[(k+2)%4])) : ai[k];
                bo[k] = s1_mode[1] ? as[k]
                                   : xt(as[k]) ^ xt(as[(k+1)%4]) ^ as[(k+1)%4] ^ as[(k+2)%4] ^ as[(k+3)%4];
            end
            for (int k = 0; k < 4; k++)
                for (int b = 0; b < 8; b++) begin
                    pre[8*d*k + d*b + s] = ci[k][b];
                    mc[8*d*k + d*b + s]  = bo[k][b];
                end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_col  <= '0;
            s2_col  <= '0;
            s1_mode <= '0;
            s1_last <= 1'b0;
            s2_last <= 1'b0;
            cnt     <= '0;
        end else begin
            if (s2_ld) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_col  <= mc;
                    s2_last <= s1_last;
                end
            end
            if (s1_ld) begin
                s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_col  <= pre;
                    s1_mode <= bus.in_mode;
                    s1_last <= cnt_last;
                    cnt     <= cnt_last ? '0 : cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_msk_aes_mixcol_pipe.sv
// tb_msk_aes_mixcol_pipe: directed vector and corner-sequence checks for the masked MixColumns pipe
module tb_msk_aes_mixcol_pipe;
    typedef struct {
        logic [1:0]  mode;
        logic [31:0] s0, s1, e0, e1;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vec [8];
    msk_aes_mixcol_pipe_if #(.d(2)) bus ();
    msk_aes_mixcol_pipe #(.d(2), .NCOL(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic logic [63:0] enc(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] c = '0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) begin
                c[16*k + 2*i]     = a[8*(3-k) + i];
                c[16*k + 2*i + 1] = b[8*(3-k) + i];
            end
        return c;
    endfunction
    function automatic logic [31:0] dec(input logic [63:0] c, input int s);
        logic [31:0] a = '0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++)
                a[8*(3-k) + i] = c[16*k + 2*i + s];
        return a;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
    endtask
    task automatic apply_one(input int i, input logic [31:0] r, input bit unmasked_only);
        logic [63:0] got;
        cyc();
        bus.in_valid  = 1'b1;
        bus.in_col    = enc(vec[i].s0 ^ r, vec[i].s1 ^ r);
        bus.in_mode   = vec[i].mode;
        bus.out_ready = 1'b1;
        #1 chk($sformatf("in_ready v%0d", i), 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        chk($sformatf("lat1 v%0d", i), 64'(bus.out_valid), 64'd0);
        cyc();
        chk($sformatf("lat2 v%0d", i), 64'(bus.out_valid), 64'd1);
        got = bus.out_col;
        if (unmasked_only)
            chk($sformatf("unmasked v%0d", i), 64'(dec(got, 0) ^ dec(got, 1)), 64'(vec[i].e0 ^ vec[i].e1));
        else
            chk($sformatf("shares v%0d", i), got, enc(vec[i].e0, vec[i].e1));
        chk($sformatf("last v%0d", i), 64'(bus.out_last), 64'(i % 4 == 3));
    endtask
    task automatic stream(input int n, input int stall);
        int ii = 0, oo = 0, c = 0, acc_stall = 0, first = -1;
        while (oo < n && c < 200) begin
            cyc();
            bus.in_valid  = ii < n;
            bus.in_col    = enc(vec[ii % 8].s0, vec[ii % 8].s1);
            bus.in_mode   = vec[ii % 8].mode;
            bus.out_ready = c >= stall;
            #1;
            if (c < stall && c >= 2)
                chk($sformatf("full in_ready c%0d", c), 64'(bus.in_ready), 64'd0);
            if (bus.in_valid && bus.in_ready) begin
                ii++;
                if (c < stall) acc_stall++;
            end
            if (bus.out_valid) begin
                chk($sformatf("stream col o%0d c%0d", oo, c), bus.out_col, enc(vec[oo % 8].e0, vec[oo % 8].e1));
                chk($sformatf("stream last o%0d c%0d", oo, c), 64'(bus.out_last), 64'(oo % 4 == 3));
                if (bus.out_ready) begin
                    if (first < 0) first = c;
                    else chk($sformatf("no bubble o%0d", oo), 64'(c), 64'(first + oo));
                    oo++;
                end
            end
            c++;
        end
        bus.in_valid = 1'b0;
        chk("stream complete", 64'(oo), 64'(n));
        if (stall > 0) chk("accepts while stalled", 64'(acc_stall), 64'd2);
        else chk("stream latency", 64'(first), 64'd2);
    endtask
    initial begin
        vec[0] = '{2'b00, 32'hdb135345, 32'h00000000, 32'h8e4da1bc, 32'h00000000};
        vec[1] = '{2'b00, 32'hf20a225c, 32'h00000000, 32'h9fdc589d, 32'h00000000};
        vec[2] = '{2'b00, 32'h29197119, 32'hf20a225c, 32'h1191f921, 32'h9fdc589d};
        vec[3] = '{2'b01, 32'h8e4da1bc, 32'h00000000, 32'hdb135345, 32'h00000000};
        vec[4] = '{2'b01, 32'h9fdc589d, 32'h00000000, 32'hf20a225c, 32'h00000000};
        vec[5] = '{2'b01, 32'h1191f921, 32'h9fdc589d, 32'h29197119, 32'hf20a225c};
        vec[6] = '{2'b10, 32'ha5a5a5a5, 32'ha4a7a6a1, 32'ha5a5a5a5, 32'ha4a7a6a1};
        vec[7] = '{2'b11, 32'h3c5a7e11, 32'h3d587d15, 32'h3c5a7e11, 32'h3d587d15};
        bus.in_valid  = 1'b0;
        bus.in_col    = '0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;
        #12;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_col", bus.out_col, 64'd0);
        chk("reset out_last", 64'(bus.out_last), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) apply_one(i, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) apply_one(i, $urandom, 1'b1);
        cyc();
        do_reset();
        stream(5, 5);
        cyc();
        do_reset();
        stream(8, 0);
        cyc();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.in_valid  = 1'b1;
            bus.in_col    = enc(vec[i].s0, vec[i].s1);
            bus.in_mode   = vec[i].mode;
            bus.out_ready = 1'b1;
        end
        cyc();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("pre-reset out_last", 64'(bus.out_last), 64'd1);
        chk("pre-reset busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 64'(bus.out_valid), 64'd0);
        chk("async busy", 64'(bus.busy), 64'd0);
        chk("async out_last", 64'(bus.out_last), 64'd0);
        chk("async out_col", bus.out_col, 64'd0);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("post-reset idle %0d", i), 64'(bus.out_valid), 64'd0);
        end
        stream(4, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
